// File: rtl/mem_load_ctrl.sv
// mem_load_ctrl: frame-based write sequencer for the synapse weight/delay memory.
// Parses header(0x01) / addr_hi / addr_lo / len / data... from a byte stream
// and issues one memory write per in-range data byte. Out-of-range data is
// counted and discarded, and the sticky error flag is raised.
module mem_load_ctrl #(
    parameter int M      = 320,
    parameter int N      = 8,
    parameter int ADDR_W = $clog2(M)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic              frame_clear,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [N-1:0]      mem_data,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_LEN,
        S_DATA
    } state_t;

    localparam logic [15:0] M16 = 16'(M);

    state_t              state_q, state_d;
    logic [15:0]         addr_q, addr_d;
    logic [8:0]          cnt_q, cnt_d;
    logic                skip_q, skip_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [N-1:0]        mdata_q, mdata_d;
    logic                we_q, we_d;
    logic                done_q, done_d;
    logic                in_range;

    assign in_range = (addr_q < M16);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            skip_q  <= 1'b0;
            err_q   <= 1'b0;
            maddr_q <= '0;
            mdata_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            skip_q  <= skip_d;
            err_q   <= err_d;
            maddr_q <= maddr_d;
            mdata_q <= mdata_d;
            we_q    <= we_d;
            done_q  <= done_d;
        end
    end

    // Next-state, frame parsing and write/done pulse generation
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        skip_d  = skip_q;
        err_d   = err_q;
        maddr_d = maddr_q;
        mdata_d = mdata_q;
        we_d    = 1'b0;
        done_d  = 1'b0;

        if (frame_clear) begin
            // Abort wins over a coincident byte, which is dropped
            state_d = S_IDLE;
            err_d   = 1'b0;
            skip_d  = 1'b0;
        end else if (byte_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (byte_in == 8'h01) begin
                        state_d = S_ADDR_HI;
                        err_d   = 1'b0;
                        skip_d  = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_ADDR_HI: begin
                    addr_d  = {byte_in, addr_q[7:0]};
                    state_d = S_ADDR_LO;
                end
                S_ADDR_LO: begin
                    addr_d  = {addr_q[15:8], byte_in};
                    state_d = S_LEN;
                end
                S_LEN: begin
                    cnt_d   = {1'b0, byte_in} + 9'd1;
                    state_d = S_DATA;
                    if (!in_range) begin
                        err_d  = 1'b1;
                        skip_d = 1'b1;
                    end
                end
                S_DATA: begin
                    if (!skip_q && in_range) begin
                        we_d    = 1'b1;
                        maddr_d = addr_q[ADDR_W-1:0];
                        mdata_d = byte_in;
                    end else begin
                        // Address ran past the end: no wrap, discard the rest
                        err_d  = 1'b1;
                        skip_d = 1'b1;
                    end
                    addr_d = addr_q + 16'd1;
                    cnt_d  = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign mem_addr = maddr_q;
    assign mem_data = mdata_q;
    assign mem_we   = we_q;
    assign done     = done_q;
    assign error    = err_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Self-checking bench for mem_load_ctrl: directed frames from the test plan
// plus randomized frames, checked against a frame-level reference model.
module tb_mem_load_ctrl;

    localparam int M      = 320;
    localparam int N      = 8;
    localparam int ADDR_W = $clog2(M);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        byte_in = '0;
    logic              byte_valid = 1'b0;
    logic              frame_clear = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [N-1:0]      mem_data;
    logic              mem_we;
    logic              busy;
    logic              done;
    logic              error;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    int obs[$];          // observed writes: addr*256 + data
    int done_cnt = 0;
    int last_addr = 0;   // expected held mem_addr / mem_data
    int last_data = 0;
    logic [7:0] pre[$];  // optional fixed payload for directed frames

    mem_load_ctrl #(.M(M), .N(N), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .frame_clear(frame_clear),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) obs.push_back(int'(mem_addr) * 256 + int'(mem_data));
        if (done) done_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        idle($urandom_range(0, maxgap));
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
    endtask

    // Send one complete frame and compare against the frame-level model
    task automatic run_frame(input int start, input int nbytes, input int maxgap);
        int ew[$];
        int a;
        logic [7:0] d;
        logic [15:0] s16;
        bit exp_err;
        s16 = 16'(start);
        obs.delete();
        done_cnt = 0;
        exp_err = 1'b0;

        send_byte(8'h01, maxgap);
        @(negedge clk);
        byte_valid = 1'b0;
        check("hdr_err_clr", int'(error), 0);
        check("hdr_busy", int'(busy), 1);

        send_byte(s16[15:8], maxgap);
        send_byte(s16[7:0], maxgap);
        send_byte(8'(nbytes - 1), maxgap);
        for (int i = 0; i < nbytes; i++) begin
            d = (pre.size() == nbytes) ? pre[i] : 8'($urandom);
            a = int'(s16) + i;
            if (a < M) begin
                ew.push_back(a * 256 + int'(d));
                last_addr = a;
                last_data = int'(d);
            end else begin
                exp_err = 1'b1;
            end
            send_byte(d, maxgap);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        check("done_lat", int'(done), 1);
        check("last_we", int'(mem_we), (int'(s16) + nbytes - 1 < M) ? 1 : 0);
        idle(3);

        check("n_writes", obs.size(), ew.size());
        for (int i = 0; i < ew.size() && i < obs.size(); i++)
            check("write", obs[i], ew[i]);
        check("done_cnt", done_cnt, 1);
        check("err_end", int'(error), int'(exp_err));
        check("busy_end", int'(busy), 0);
        check("hold_addr", int'(mem_addr), last_addr);
        check("hold_data", int'(mem_data), last_data);
        pre.delete();
    endtask

    // Start a frame at 319 with 4 data bytes, abort after two of them
    task automatic abort_frame(input bit use_reset);
        obs.delete();
        done_cnt = 0;
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        send_byte(8'h3F, 0);
        send_byte(8'h03, 0);
        send_byte(8'hC3, 1);
        send_byte(8'h5A, 1);
        if (use_reset) begin
            @(negedge clk);
            byte_valid = 1'b0;
            #2;
            check("pre_abort_err", int'(error), 1);
            rst_n = 1'b0;
            #1;
            check("rst_busy", int'(busy), 0);
            check("rst_err", int'(error), 0);
            check("rst_we", int'(mem_we), 0);
            check("rst_addr", int'(mem_addr), 0);
            last_addr = 0;
            last_data = 0;
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            @(negedge clk);
            byte_in     = 8'h99;
            byte_valid  = 1'b1;
            frame_clear = 1'b1;
            @(negedge clk);
            byte_valid  = 1'b0;
            frame_clear = 1'b0;
            check("clr_busy", int'(busy), 0);
            check("clr_err", int'(error), 0);
            check("clr_we", int'(mem_we), 0);
            check("clr_done", int'(done), 0);
            last_addr = 319;
            last_data = 8'hC3;
        end
        idle(6);
        check("abort_writes", obs.size(), 1);
        if (obs.size() > 0) check("abort_w0", obs[0], 319 * 256 + 8'hC3);
        check("abort_done", done_cnt, 0);
        check("abort_busy", int'(busy), 0);
    endtask

    initial begin
        int st;
        int sel;
        repeat (3) @(negedge clk);
        check("rst_addr0", int'(mem_addr), 0);
        check("rst_data0", int'(mem_data), 0);
        check("rst_we0", int'(mem_we), 0);
        check("rst_busy0", int'(busy), 0);
        check("rst_done0", int'(done), 0);
        check("rst_err0", int'(error), 0);
        rst_n = 1'b1;
        idle(2);

        pre = '{8'hAA, 8'hBB, 8'hCC};
        run_frame(5, 3, 0);
        pre = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(318, 4, 0);
        pre = '{8'h77};
        run_frame(320, 1, 1);
        pre = '{8'h5A};
        run_frame(0, 1, 1);

        obs.delete();
        send_byte(8'h7F, 0);
        idle(2);
        check("bad_hdr_err", int'(error), 1);
        check("bad_hdr_busy", int'(busy), 0);
        check("bad_hdr_we", obs.size(), 0);

        run_frame(16, 256, 3);

        abort_frame(1'b0);
        run_frame(100, 4, 1);
        abort_frame(1'b1);
        run_frame(200, 4, 1);

        for (int k = 0; k < 25; k++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       st = $urandom_range(0, M - 1);
                1:       st = M - 1 - $urandom_range(0, 8);
                2:       st = M + $urandom_range(0, 5);
                default: st = $urandom_range(0, 65535);
            endcase
            if ($urandom_range(0, 4) == 0) begin
                send_byte(8'($urandom_range(2, 255)), 1);
                idle(2);
                check("rnd_bad_hdr", int'(error), 1);
            end
            run_frame(st, $urandom_range(1, 20), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_load_ctrl.md
Name: mem_load_ctrl

Overview:
- Frame-based write sequencer for the synapse weight/delay memory (M words × N bits).
- Consumes a byte stream from the upstream serial deserializer. Each frame is a header, a start address, a length and the data bytes.
- Drives the memory's addr/data_in/write_enable ports with auto-incrementing addresses.
- Flags malformed or out-of-range frames and reports frame completion to the top level.

Parameters:
- M, 320, number of memory words
- N, 8, memory word width; must equal 8, one data byte per word
- ADDR_W, $clog2(M), memory address width

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- byte_in  input  8  byte from deserializer; sampled only when byte_valid=1
- byte_valid  input  1  one-cycle strobe, at most one byte per cycle
- frame_clear  input  1  synchronous abort: return to IDLE, clear error
- mem_addr  output  ADDR_W  address to memory
- mem_data  output  N  write data to memory
- mem_we  output  1  write enable to memory, one cycle per data byte
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse when a frame's last byte is consumed
- error  output  1  sticky error flag

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE.
  - mem_addr=0, mem_data=0, mem_we=0, busy=0, done=0, error=0.
  - Internal address register, count register and flags cleared.
- States: IDLE, ADDR_HI, ADDR_LO, LEN, DATA. State advances only on a cycle with byte_valid=1.
- IDLE:
  - byte 0x01 → ADDR_HI, and error is cleared.
  - Any other byte → stay in IDLE, set error. No write occurs.
- ADDR_HI: latch byte as addr[15:8] → ADDR_LO.
- ADDR_LO: latch byte as addr[7:0] → LEN.
- LEN: latch count = byte + 1 (range 1..256, held in a 9-bit register) → DATA.
  - If the 16-bit address ≥ M: set error and set the internal "skip" flag.
- DATA, per valid byte:
  - If skip=0 and the current address < M: next cycle mem_we=1, mem_addr=current address, mem_data=byte. Latency is one clock from byte_valid to mem_we.
  - If the address reaches M during the burst, no wrap occurs. Writes stop, error is set, skip is set.
  - Remaining bytes are still counted and discarded.
  - Address increments by 1 per byte; count decrements by 1.
  - On the byte that brings count to 0: done=1 on the same cycle as the final mem_we slot (one clock after that byte), then → IDLE.
  - done pulses even when error=1.
- Output timing:
  - mem_we and done are registered single-cycle pulses, low on all other cycles.
  - mem_addr and mem_data hold their last values when mem_we=0.
- busy: combinational from state, high in every state except IDLE.
- error: sticky. Cleared only by rst_n, by frame_clear, or by acceptance of a 0x01 header in IDLE.
- frame_clear=1:
  - Next state IDLE; error=0; any mem_we or done pending for that edge is suppressed.
  - Takes priority over a simultaneous byte_valid, which is dropped.
- Reset mid-frame: frame abandoned, no partial-state carry-over. The next frame must start with a header.
- Address arithmetic:
  - Held internally as 16 bits for the range compare.
  - mem_addr = lower ADDR_W bits, driven only when the address < M.

Test Plan:
- Frame 01 00 05 02 AA BB CC → mem_we pulses at addr 5,6,7 with data AA,BB,CC on consecutive valid bytes. done pulses with the CC write; error=0; busy returns to 0.
- Frame 01 01 3E 03 11 22 33 44 (start 318, M=320) → writes 318=11, 319=22 only. 33/44 consumed without mem_we; error=1; done pulses after 44.
- Frame 01 01 40 00 77 (addr 320) → no mem_we, error=1, done pulses. A following valid frame 01 00 00 00 5A → error clears at header; write 0=5A.
- Byte 0x7F in IDLE → error=1, state stays IDLE, busy=0, no mem_we.
- Frame 01 00 10 FF followed by 256 bytes with gaps between byte_valid strobes → 256 writes at addr 16..271, one per strobe, done exactly once.
- frame_clear asserted, or rst_n pulsed low, after 2 of 4 data bytes → busy=0 immediately/next edge, error=0, no further writes. A new frame then proceeds normally.
